// File: rtl/dmem_ctrl.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// accesses a byte-lane RAM and returns a one-cycle done pulse with data or err.
module dmem_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lw_en,
   input  logic        sw_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic [ADDR_W+1:0]   addr_reg;
   logic [31:0]         wdata_reg;
   logic [2:0]          f3_reg;
   logic                store_reg;
   logic                err_reg;

   logic                req;
   logic                legal;
   logic                access;
   logic [3:0]          lane_we;
   logic [ADDR_W-1:0]   word_idx;
   logic [31:0]         word;
   logic [31:0]         byte_shift;
   logic [31:0]         half_shift;
   logic [31:0]         load_val;

   assign req = lw_en | sw_en;

   // Legality is judged on the live inputs so an illegal request can skip WAIT.
   always_comb begin
      legal = 1'b1;
      if (lw_en && sw_en) begin
         legal = 1'b0;
      end else if (lw_en) begin
         case (funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~addr[0];
            3'b010:         legal = (addr[1:0] == 2'b00);
            default:        legal = 1'b0;
         endcase
      end else begin
         case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
         endcase
      end
      if ((addr >> (ADDR_W + 2)) != 32'd0) begin
         legal = 1'b0;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               if (legal) begin
                  state_next = WAIT;
                  cnt_next   = CNT_INIT;
               end else begin
                  state_next = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         addr_reg  <= '0;
         wdata_reg <= 32'd0;
         f3_reg    <= 3'd0;
         store_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && req) begin
            addr_reg  <= addr[ADDR_W+1:0];
            wdata_reg <= wdata;
            f3_reg    <= funct3;
            store_reg <= sw_en;
            err_reg   <= ~legal;
         end
      end
   end

   assign access   = (state_reg == WAIT) && (cnt_reg == 4'd0);
   assign word_idx = addr_reg[ADDR_W+1:2];

   always_comb begin
      lane_we = 4'b0000;
      case (f3_reg[1:0])
         2'b00:   lane_we[addr_reg[1:0]] = 1'b1;
         2'b01:   lane_we = addr_reg[1] ? 4'b1100 : 4'b0011;
         default: lane_we = 4'b1111;
      endcase
   end

   // One RAM per byte lane so partial stores map onto plain write enables.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] ram [2**ADDR_W];
         logic [7:0] rd_reg;
         logic [7:0] wbyte;

         always_comb begin
            case (f3_reg[1:0])
               2'b00:   wbyte = wdata_reg[7:0];
               2'b01:   wbyte = wdata_reg[(gi % 2)*8 +: 8];
               default: wbyte = wdata_reg[gi*8 +: 8];
            endcase
         end

         always_ff @(posedge clk) begin
            if (access && store_reg && lane_we[gi] && !rst) begin
               ram[word_idx] <= wbyte;
            end
            if (access) begin
               rd_reg <= ram[word_idx];
            end
         end
      end
   endgenerate

   assign word = {g_lane[3].rd_reg, g_lane[2].rd_reg, g_lane[1].rd_reg, g_lane[0].rd_reg};

   assign byte_shift = word >> {addr_reg[1:0], 3'b000};
   assign half_shift = word >> {addr_reg[1], 4'b0000};

   always_comb begin
      case (f3_reg)
         3'b000:  load_val = {{24{byte_shift[7]}}, byte_shift[7:0]};
         3'b100:  load_val = {24'd0, byte_shift[7:0]};
         3'b001:  load_val = {{16{half_shift[15]}}, half_shift[15:0]};
         3'b101:  load_val = {16'd0, half_shift[15:0]};
         default: load_val = word;
      endcase
   end

   assign busy  = (state_reg != IDLE);
   assign done  = (state_reg == RESP);
   assign err   = (state_reg == RESP) && err_reg;
   assign rdata = ((state_reg == RESP) && !err_reg && !store_reg) ? load_val : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two instances (LATENCY=2 and LATENCY=1) checked
// every cycle against a word-array model of the memory and the timing rules.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic [1:0]  rst = 2'b11;
   logic [1:0]  lw_en = 2'b00;
   logic [1:0]  sw_en = 2'b00;
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic [2:0]  funct3 [2];
   logic [1:0]  busy, done, err;
   logic [31:0] rdata  [2];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   // Expected behaviour per instance, set by the driver from the model.
   int          exp_cycle [2];
   int          busy_from [2];
   int          busy_to   [2];
   logic [31:0] exp_rdata [2];
   logic        exp_err   [2];
   logic [31:0] cap_rdata [2];
   logic [31:0] mem_m [2][1024];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_ctrl #(.ADDR_W(10), .LATENCY(2)) u_dut0 (
      .clk(clk), .rst(rst[0]), .lw_en(lw_en[0]), .sw_en(sw_en[0]),
      .addr(addr[0]), .wdata(wdata[0]), .funct3(funct3[0]),
      .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0]));

   dmem_ctrl #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .lw_en(lw_en[1]), .sw_en(sw_en[1]),
      .addr(addr[1]), .wdata(wdata[1]), .funct3(funct3[1]),
      .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1]));

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, inst, cyc, act, exp);
   endtask

   function automatic bit m_legal(input bit lw, input bit sw, input logic [31:0] a,
                                  input logic [2:0] f);
      int size;
      if (lw && sw) return 1'b0;
      if (a >= 32'h1000) return 1'b0;
      if (lw && !(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
      if (sw && !(f inside {3'b000, 3'b001, 3'b010})) return 1'b0;
      size = 1 << f[1:0];
      return (a % size) == 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                          input logic [2:0] f);
      int sh = (a % 4) * 8;
      logic [31:0] v;
      if (f[1:0] == 2'b00) begin
         v = (w >> sh) & 32'hFF;
         if (!f[2] && v >= 32'd128) v = v - 32'd256;
      end else if (f[1:0] == 2'b01) begin
         v = (w >> sh) & 32'hFFFF;
         if (!f[2] && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] a,
                                           input logic [31:0] wd, input logic [2:0] f);
      int n = 1 << f[1:0];
      for (int j = 0; j < n; j++) w[((a % 4) + j)*8 +: 8] = wd[j*8 +: 8];
      return w;
   endfunction

   // Per-cycle comparison of both instances against the expected schedule.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            chk("done", i, {31'd0, done[i]}, {31'd0, (cyc == exp_cycle[i])});
            chk("busy", i, {31'd0, busy[i]},
                {31'd0, (cyc >= busy_from[i]) && (cyc <= busy_to[i])});
            chk("rdata", i, rdata[i], (cyc == exp_cycle[i]) ? exp_rdata[i] : 32'd0);
            chk("err", i, {31'd0, err[i]}, {31'd0, (cyc == exp_cycle[i]) && exp_err[i]});
            if (cyc == exp_cycle[i]) cap_rdata[i] <= rdata[i];
         end
      end
   end

   // Drive one request; inject adds an ignored SW to 0x20 during WAIT,
   // abort asserts rst in the final WAIT cycle.
   task automatic req(input int i, input bit lw, input bit sw, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f, input bit lit,
                      input logic [31:0] lit_v, input bit inject, input bit abort);
      int k;
      bit ok;
      @(posedge clk); #1;
      lw_en[i] = lw; sw_en[i] = sw; addr[i] = a; wdata[i] = wd; funct3[i] = f;
      k  = cyc;
      ok = m_legal(lw, sw, a, f);
      exp_err[i]   = !ok;
      exp_rdata[i] = (ok && lw) ? m_load(mem_m[i][a[11:2]], a, f) : 32'd0;
      exp_cycle[i] = ok ? k + lat_of(i) + 1 : k + 1;
      busy_from[i] = k + 1;
      busy_to[i]   = exp_cycle[i];
      cap_rdata[i] = 32'hBAD0BAD0;
      @(posedge clk); #1;
      lw_en[i] = 1'b0; sw_en[i] = 1'b0;
      if (inject) begin
         sw_en[i] = 1'b1; addr[i] = 32'h20; wdata[i] = 32'h55555555; funct3[i] = 3'b010;
         @(posedge clk); #1;
         sw_en[i] = 1'b0;
      end
      if (abort) begin
         repeat (lat_of(i) - 1) @(posedge clk);
         #1;
         rst[i] = 1'b1;
         exp_cycle[i] = -1;
         busy_to[i]   = cyc;
         @(posedge clk); #1;
         rst[i] = 1'b0;
         repeat (3) @(posedge clk);
         $display("txn inst%0d sw addr=%h aborted by reset", i, a);
      end else begin
         while (cyc <= exp_cycle[i]) @(posedge clk);
         #1;
         if (ok && sw) mem_m[i][a[11:2]] = m_store(mem_m[i][a[11:2]], a, wd, f);
         $display("txn inst%0d lw=%0b sw=%0b addr=%h f3=%b -> err=%0b rdata=%h",
                  i, lw, sw, a, f, exp_err[i], cap_rdata[i]);
         if (lit) chk("literal", i, cap_rdata[i], lit_v);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         addr[i] = 32'd0; wdata[i] = 32'd0; funct3[i] = 3'd0;
         exp_cycle[i] = -1; busy_from[i] = 0; busy_to[i] = -1;
         exp_rdata[i] = 32'd0; exp_err[i] = 1'b0; cap_rdata[i] = 32'd0;
      end
      @(posedge clk); #1;
      rst = 2'b00;
      chk_on = 1'b1;

      // Word round trip, then lanes and sign extension.
      req(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'd0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 3'b010, 1, 32'hDEADBEEF, 0, 0);
      req(0, 0, 1, 32'h10, 32'h80F07F01, 3'b010, 0, 32'd0, 0, 0);
      req(0, 1, 0, 32'h13, 32'd0, 3'b000, 1, 32'hFFFFFF80, 0, 0);
      req(0, 1, 0, 32'h13, 32'd0, 3'b100, 1, 32'h00000080, 0, 0);
      req(0, 1, 0, 32'h12, 32'd0, 3'b001, 1, 32'hFFFF80F0, 0, 0);
      req(0, 1, 0, 32'h12, 32'd0, 3'b101, 1, 32'h000080F0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 3'b000, 1, 32'h00000001, 0, 0);
      req(0, 0, 1, 32'h11, 32'hFFFFFFAA, 3'b000, 0, 32'd0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 3'b010, 1, 32'h80F0AA01, 0, 0);
      req(0, 0, 1, 32'h14, 32'd0, 3'b010, 0, 32'd0, 0, 0);
      req(0, 0, 1, 32'h16, 32'h1234BEEF, 3'b001, 0, 32'd0, 0, 0);
      req(0, 1, 0, 32'h14, 32'd0, 3'b010, 1, 32'hBEEF0000, 0, 0);

      // Illegal requests, then confirm 0x10 untouched.
      req(0, 1, 0, 32'h12, 32'd0, 3'b010, 1, 32'd0, 0, 0);
      req(0, 0, 1, 32'h11, 32'h00001234, 3'b001, 1, 32'd0, 0, 0);
      req(0, 1, 1, 32'h10, 32'h11111111, 3'b010, 1, 32'd0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 3'b011, 1, 32'd0, 0, 0);
      req(0, 1, 0, 32'h00010000, 32'd0, 3'b010, 1, 32'd0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 3'b010, 1, 32'h80F0AA01, 0, 0);

      // Store strobe during WAIT is ignored.
      req(0, 0, 1, 32'h20, 32'h11112222, 3'b010, 0, 32'd0, 0, 0);
      req(0, 1, 0, 32'h10, 32'd0, 3'b010, 1, 32'h80F0AA01, 1, 0);
      req(0, 1, 0, 32'h20, 32'd0, 3'b010, 1, 32'h11112222, 0, 0);

      // Reset in the final WAIT cycle cancels the store.
      req(0, 0, 1, 32'h30, 32'hCAFEF00D, 3'b010, 0, 32'd0, 0, 0);
      req(0, 0, 1, 32'h30, 32'h12345678, 3'b010, 0, 32'd0, 0, 1);
      req(0, 1, 0, 32'h30, 32'd0, 3'b010, 1, 32'hCAFEF00D, 0, 0);

      // LATENCY=1 instance, each request issued the cycle after the previous done.
      req(1, 0, 1, 32'h40, 32'h0BADCAFE, 3'b010, 0, 32'd0, 0, 0);
      req(1, 1, 0, 32'h40, 32'd0, 3'b010, 1, 32'h0BADCAFE, 0, 0);
      req(1, 1, 0, 32'h40, 32'd0, 3'b010, 1, 32'h0BADCAFE, 0, 0);
      req(1, 1, 0, 32'h41, 32'd0, 3'b100, 1, 32'h000000CA, 0, 0);
      req(1, 1, 0, 32'h42, 32'd0, 3'b001, 1, 32'h00000BAD, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
